// File: rtl/multicycle_control_if.sv
// Control-side bundle for the multicycle RV32 datapath: opcode and memory
// handshake in, datapath strobes, ALU mode, status flags and debug state out.
interface multicycle_control_if;
    logic [6:0] opcode;
    logic       memReady;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       aluOp0;
    logic       aluOp1;
    logic       pcSource;
    logic       instrRetired;
    logic       illegalOp;
    logic       busTimeout;
    logic [3:0] state;

    // The controller drives the strobes and observes opcode/memReady.
    modport master (
        input  opcode, memReady,
        output pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
               memToReg, regWrite, aluSrcA, aluSrcB, aluOp0, aluOp1,
               pcSource, instrRetired, illegalOp, busTimeout, state
    );

    // The datapath/memory side supplies opcode/memReady and consumes strobes.
    modport slave (
        output opcode, memReady,
        input  pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
               memToReg, regWrite, aluSrcA, aluSrcB, aluOp0, aluOp1,
               pcSource, instrRetired, illegalOp, busTimeout, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32 subset (R-type, lw, sw, beq).
// Memory states wait on memReady with a bounded wait counter; unknown
// opcodes and memory timeouts park the machine in ERROR until reset.
module multicycle_control #(
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_control_if.master  bus
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        ALU_WB    = 4'd7,
        BRANCH    = 4'd8,
        ERROR     = 4'd9
    } stateT;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_BEQ    = 7'b1100011;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    stateT            r_state;
    logic [CNT_W-1:0] r_waitCnt;
    logic [6:0]       r_opcode;
    logic             r_illegalOp;
    logic             r_busTimeout;

    // State sequencing, wait counting, opcode latch and sticky error flags.
    // The wait counter is zeroed on every transition so it always starts
    // fresh when a memory-waiting state is entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= FETCH;
            r_waitCnt    <= '0;
            r_opcode     <= '0;
            r_illegalOp  <= 1'b0;
            r_busTimeout <= 1'b0;
        end else begin
            case (r_state)
                FETCH, MEM_READ, MEM_WRITE: begin
                    if (bus.memReady) begin
                        r_waitCnt <= '0;
                        case (r_state)
                            FETCH:    r_state <= DECODE;
                            MEM_READ: r_state <= MEM_WB;
                            default:  r_state <= FETCH;
                        endcase
                    end else if (r_waitCnt == LAST_WAIT) begin
                        r_waitCnt    <= '0;
                        r_state      <= ERROR;
                        r_busTimeout <= 1'b1;
                    end else begin
                        r_waitCnt <= r_waitCnt + CNT_W'(1);
                    end
                end
                DECODE: begin
                    r_opcode  <= bus.opcode;
                    r_waitCnt <= '0;
                    case (bus.opcode)
                        OP_RTYPE:     r_state <= EXEC_R;
                        OP_LW, OP_SW: r_state <= MEM_ADDR;
                        OP_BEQ:       r_state <= BRANCH;
                        default: begin
                            r_state     <= ERROR;
                            r_illegalOp <= 1'b1;
                        end
                    endcase
                end
                MEM_ADDR: begin
                    r_waitCnt <= '0;
                    r_state   <= (r_opcode == OP_LW) ? MEM_READ : MEM_WRITE;
                end
                EXEC_R: begin
                    r_waitCnt <= '0;
                    r_state   <= ALU_WB;
                end
                MEM_WB, ALU_WB, BRANCH: begin
                    r_waitCnt <= '0;
                    r_state   <= FETCH;
                end
                ERROR: begin
                    r_state <= ERROR;
                end
                default: begin
                    r_waitCnt <= '0;
                    r_state   <= ERROR;
                end
            endcase
        end
    end

    // Moore output decode; only FETCH's IR/PC load and MEM_WRITE's retire
    // pulse also look at memReady, so they fire only when memory completes.
    always_comb begin
        bus.pcWrite      = 1'b0;
        bus.pcWriteCond  = 1'b0;
        bus.iorD         = 1'b0;
        bus.memRead      = 1'b0;
        bus.memWrite     = 1'b0;
        bus.irWrite      = 1'b0;
        bus.memToReg     = 1'b0;
        bus.regWrite     = 1'b0;
        bus.aluSrcA      = 1'b0;
        bus.aluSrcB      = 2'b00;
        bus.aluOp0       = 1'b0;
        bus.aluOp1       = 1'b0;
        bus.pcSource     = 1'b0;
        bus.instrRetired = 1'b0;
        case (r_state)
            FETCH: begin
                bus.memRead = 1'b1;
                bus.aluSrcB = 2'b01;
                bus.irWrite = bus.memReady;
                bus.pcWrite = bus.memReady;
            end
            DECODE: begin
                bus.aluSrcB = 2'b11;
            end
            MEM_ADDR: begin
                bus.aluSrcA = 1'b1;
                bus.aluSrcB = 2'b10;
            end
            MEM_READ: begin
                bus.memRead = 1'b1;
                bus.iorD    = 1'b1;
            end
            MEM_WB: begin
                bus.regWrite     = 1'b1;
                bus.memToReg     = 1'b1;
                bus.instrRetired = 1'b1;
            end
            MEM_WRITE: begin
                bus.memWrite     = 1'b1;
                bus.iorD         = 1'b1;
                bus.instrRetired = bus.memReady;
            end
            EXEC_R: begin
                bus.aluSrcA = 1'b1;
                bus.aluOp1  = 1'b1;
            end
            ALU_WB: begin
                bus.regWrite     = 1'b1;
                bus.instrRetired = 1'b1;
            end
            BRANCH: begin
                bus.aluSrcA      = 1'b1;
                bus.aluOp0       = 1'b1;
                bus.pcWriteCond  = 1'b1;
                bus.pcSource     = 1'b1;
                bus.instrRetired = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Status and debug outputs straight from their registers.
    always_comb begin
        bus.state      = r_state;
        bus.illegalOp  = r_illegalOp;
        bus.busTimeout = r_busTimeout;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: each driven cycle pushes the
// expected state, strobes and flags to a scoreboard, which is popped and
// compared on the following falling edge.
module tb_multicycle_control;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [14:0] outs;
        logic [1:0]  flags;
    } expT;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    expT  sbQ[$];

    multicycle_control_if bus ();

    multicycle_control #(.TIMEOUT(8), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected strobes for a state, packed as
    // {pcWrite,pcWriteCond,iorD,memRead,memWrite,irWrite,memToReg,regWrite,
    //  aluSrcA,aluSrcB[1:0],aluOp1,aluOp0,pcSource,instrRetired}.
    function automatic logic [14:0] outModel(input logic [3:0] s, input logic mr);
        logic [14:0] o;
        o = '0;
        case (s)
            4'd0: begin o[11] = 1'b1; o[5:4] = 2'b01; o[9] = mr; o[14] = mr; end
            4'd1: begin o[5:4] = 2'b11; end
            4'd2: begin o[6] = 1'b1; o[5:4] = 2'b10; end
            4'd3: begin o[11] = 1'b1; o[12] = 1'b1; end
            4'd4: begin o[7] = 1'b1; o[8] = 1'b1; o[0] = 1'b1; end
            4'd5: begin o[10] = 1'b1; o[12] = 1'b1; o[0] = mr; end
            4'd6: begin o[6] = 1'b1; o[3] = 1'b1; end
            4'd7: begin o[7] = 1'b1; o[0] = 1'b1; end
            4'd8: begin o[6] = 1'b1; o[2] = 1'b1; o[13] = 1'b1; o[1] = 1'b1; o[0] = 1'b1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs and queue what the DUT should show during it.
    task automatic applyStimulus(input string tag, input logic [6:0] op,
                                 input logic mr, input logic rst,
                                 input logic [3:0] expSt, input logic expIll,
                                 input logic expTo);
        expT e;
        bus.opcode   = op;
        bus.memReady = mr;
        reset        = rst;
        e.tag   = tag;
        e.st    = expSt;
        e.outs  = outModel(expSt, mr);
        e.flags = {expIll, expTo};
        sbQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: compare DUT outputs mid-cycle against the queue.
    always @(negedge clk) begin
        if (sbQ.size() > 0) begin
            expT e;
            e = sbQ.pop_front();
            checkOutput({e.tag, "/state"}, 32'(bus.state), 32'(e.st));
            checkOutput({e.tag, "/strobes"},
                        32'({bus.pcWrite, bus.pcWriteCond, bus.iorD, bus.memRead,
                             bus.memWrite, bus.irWrite, bus.memToReg, bus.regWrite,
                             bus.aluSrcA, bus.aluSrcB, bus.aluOp1, bus.aluOp0,
                             bus.pcSource, bus.instrRetired}),
                        32'(e.outs));
            checkOutput({e.tag, "/flags"}, 32'({bus.illegalOp, bus.busTimeout}),
                        32'(e.flags));
        end
    end

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bus.opcode   = '0;
        bus.memReady = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus("reset", 7'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);

        // R-type with memReady tied high: 4 cycles.
        applyStimulus("r_fetch",  OP_R, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus("r_decode", OP_R, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
        applyStimulus("r_exec",   OP_R, 1'b1, 1'b0, 4'd6, 1'b0, 1'b0);
        applyStimulus("r_wb",     OP_R, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0);

        // R-type with memReady low outside the memory states: ignored.
        applyStimulus("r2_fetch",  OP_R, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus("r2_decode", OP_R, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0);
        applyStimulus("r2_exec",   OP_R, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0);
        applyStimulus("r2_wb",     OP_R, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0);

        // lw with three wait cycles; opcode changes after DECODE to prove it is latched.
        applyStimulus("lw_fetch",  OP_LW, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus("lw_decode", OP_LW, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
        applyStimulus("lw_addr",   OP_SW, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus("lw_wait", OP_SW, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
        applyStimulus("lw_read",   OP_SW, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
        applyStimulus("lw_wb",     OP_SW, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0);

        // beq: 3 cycles.
        applyStimulus("beq_fetch",  OP_BEQ, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus("beq_decode", OP_BEQ, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
        applyStimulus("beq_branch", OP_BEQ, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0);

        // sw that never gets memReady: 8 wait cycles then ERROR with busTimeout.
        applyStimulus("swto_fetch",  OP_SW, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus("swto_decode", OP_SW, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
        applyStimulus("swto_addr",   OP_SW, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            applyStimulus("swto_wait", OP_SW, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0);
        applyStimulus("swto_err",   OP_SW, 1'b0, 1'b0, 4'd9, 1'b0, 1'b1);
        applyStimulus("swto_hold",  OP_SW, 1'b1, 1'b0, 4'd9, 1'b0, 1'b1);
        applyStimulus("swto_rst",   OP_SW, 1'b0, 1'b1, 4'd9, 1'b0, 1'b1);
        applyStimulus("swto_after", OP_SW, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Illegal opcode: ERROR with illegalOp, strobes quiet for 10 cycles.
        applyStimulus("ill_fetch",  OP_BAD, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus("ill_decode", OP_BAD, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            applyStimulus("ill_hold", OP_R, 1'(i % 2), 1'b0, 4'd9, 1'b1, 1'b0);
        applyStimulus("ill_rst",    OP_R, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0);

        // FETCH waits 7 cycles, memReady arrives on the last allowed cycle.
        for (int i = 0; i < 7; i++)
            applyStimulus("edge_wait", OP_LW, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus("edge_fetch",  OP_LW, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus("edge_decode", OP_LW, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
        applyStimulus("edge_addr",   OP_LW, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0);
        applyStimulus("edge_wait2",  OP_LW, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
        applyStimulus("midrd_rst",   OP_LW, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
        applyStimulus("midrd_after", OP_LW, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

        // sw completing after two waits: retire pulse only on the memReady cycle.
        applyStimulus("sw_fetch",  OP_SW, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus("sw_decode", OP_SW, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
        applyStimulus("sw_addr",   OP_SW, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0);
        applyStimulus("sw_wait",   OP_SW, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0);
        applyStimulus("sw_wait",   OP_SW, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0);
        applyStimulus("sw_write",  OP_SW, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0);
        applyStimulus("sw_done",   OP_SW, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
